// File: rtl/step_pulse_gen.sv
// step_pulse_gen: programmable-rate step pulse source.
// Emits exactly `rate` one-cycle pulses per second, spread evenly by a
// fractional accumulator. Offers fixed walk/jog/run rates and a 10-second
// repeating hybrid profile. Reports second ticks, elapsed seconds and a
// running pulse total.
// Handshake: none. `start` is a plain level: 1 = generate, 0 = stop.
module step_pulse_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        pulse,
  output logic        sec_tick,
  output logic        running,
  output logic [7:0]  rate,
  output logic [7:0]  elapsed_sec,
  output logic [15:0] total_pulses
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] CLK_HZ_32 = CLK_HZ;
  localparam logic [32:0] CLK_HZ_W  = {1'b0, CLK_HZ_32};
  localparam logic [31:0] SEC_LAST  = CLK_HZ_32 - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sec_cnt_q, sec_cnt_d;
  logic [3:0]  hyb_idx_q, hyb_idx_d;
  logic        pulse_q, pulse_d;
  logic        sec_tick_q, sec_tick_d;
  logic [7:0]  rate_q, rate_d;
  logic [7:0]  elapsed_q, elapsed_d;
  logic [15:0] total_q, total_d;

  logic [32:0] sum;
  logic [3:0]  hyb_next;

  // Rate in pulses per second for a mode and hybrid profile step.
  function automatic logic [7:0] rate_lookup(input logic [1:0] m,
                                             input logic [3:0] idx);
    logic [7:0] r;
    case (m)
      2'b00:   r = 8'd32;
      2'b01:   r = 8'd64;
      2'b10:   r = 8'd128;
      default: begin
        case (idx)
          4'd0:    r = 8'd20;
          4'd1:    r = 8'd33;
          4'd2:    r = 8'd66;
          4'd3:    r = 8'd27;
          4'd4:    r = 8'd70;
          4'd5:    r = 8'd30;
          4'd6:    r = 8'd19;
          4'd7:    r = 8'd30;
          4'd8:    r = 8'd33;
          default: r = 8'd69;
        endcase
      end
    endcase
    return r;
  endfunction

  // Next-state logic: run/stop control, fractional accumulator, second counter.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sec_cnt_d  = sec_cnt_q;
    hyb_idx_d  = hyb_idx_q;
    pulse_d    = 1'b0;
    sec_tick_d = 1'b0;
    rate_d     = rate_q;
    elapsed_d  = elapsed_q;
    total_d    = total_q;
    sum        = {1'b0, acc_q} + {25'd0, rate_q};
    hyb_next   = (hyb_idx_q == 4'd9) ? 4'd0 : hyb_idx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          acc_d     = 32'd0;
          sec_cnt_d = 32'd0;
          hyb_idx_d = 4'd0;
          elapsed_d = 8'd0;
          total_d   = 16'd0;
          rate_d    = rate_lookup(mode, 4'd0);
        end
      end
      default: begin
        if (!start) begin
          // Stop immediately; counters and rate hold for inspection.
          state_d = S_IDLE;
        end else begin
          // Accumulator always adds the rate in force before any tick update.
          if (sum >= CLK_HZ_W) begin
            acc_d   = sum[31:0] - CLK_HZ_32;
            pulse_d = 1'b1;
            if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
          end else begin
            acc_d = sum[31:0];
          end
          // A mode change only takes effect here, at the second boundary.
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d  = 32'd0;
            sec_tick_d = 1'b1;
            if (elapsed_q != 8'hFF) elapsed_d = elapsed_q + 8'd1;
            hyb_idx_d  = hyb_next;
            rate_d     = rate_lookup(mode, hyb_next);
          end else begin
            sec_cnt_d = sec_cnt_q + 32'd1;
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= 32'd0;
      sec_cnt_q  <= 32'd0;
      hyb_idx_q  <= 4'd0;
      pulse_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      rate_q     <= 8'd0;
      elapsed_q  <= 8'd0;
      total_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sec_cnt_q  <= sec_cnt_d;
      hyb_idx_q  <= hyb_idx_d;
      pulse_q    <= pulse_d;
      sec_tick_q <= sec_tick_d;
      rate_q     <= rate_d;
      elapsed_q  <= elapsed_d;
      total_q    <= total_d;
    end
  end

  assign running      = (state_q == S_RUN);
  assign pulse        = pulse_q;
  assign sec_tick     = sec_tick_q;
  assign rate         = rate_q;
  assign elapsed_sec  = elapsed_q;
  assign total_pulses = total_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen at CLK_HZ = 1000.
// A negedge monitor counts pulses per second window and, at each sec_tick,
// compares the count and the new rate against entries queued by the driver.
module tb_step_pulse_gen;

  localparam int unsigned CLK_HZ = 1000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic        pulse;
  logic        sec_tick;
  logic        running;
  logic [7:0]  rate;
  logic [7:0]  elapsed_sec;
  logic [15:0] total_pulses;

  step_pulse_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode         (mode),
    .pulse        (pulse),
    .sec_tick     (sec_tick),
    .running      (running),
    .rate         (rate),
    .elapsed_sec  (elapsed_sec),
    .total_pulses (total_pulses)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-second record: {rate after tick, pulses in that second}
  logic [15:0] exp_q[$];
  int          win_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hybrid profile and fixed rates as listed for the block.
  function automatic logic [7:0] exp_rate(input logic [1:0] m, input int idx);
    logic [7:0] hyb [10];
    hyb = '{8'd20, 8'd33, 8'd66, 8'd27, 8'd70, 8'd30, 8'd19, 8'd30, 8'd33, 8'd69};
    case (m)
      2'b00:   return 8'd32;
      2'b01:   return 8'd64;
      2'b10:   return 8'd128;
      default: return hyb[idx % 10];
    endcase
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] e;
    if (!running) begin
      win_cnt = 0;
    end else begin
      if (pulse) win_cnt++;
      if (sec_tick) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_tick: got tick with empty queue (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_pulses_per_sec", win_cnt, {24'd0, e[7:0]});
          check("sb_rate_at_tick", {24'd0, rate}, {24'd0, e[15:8]});
        end
        win_cnt = 0;
      end
    end
  end

  // Driver helpers
  task automatic push_seconds(input logic [1:0] m, input int secs);
    for (int s = 0; s < secs; s++)
      exp_q.push_back({exp_rate(m, s + 1), exp_rate(m, s)});
  endtask

  task automatic stop_run();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stop_running", {31'd0, running}, 32'd0);
    check("stop_pulse", {31'd0, pulse}, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          secs;
    logic [7:0]  exp_elapsed;
    logic [15:0] exp_total;
    logic [7:0]  exp_rate;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n;
    int last;
    int bad;
    int found;
    int after;

    vecs[0] = '{mode: 2'b00, secs: 3,  exp_elapsed: 8'd3,  exp_total: 16'd96,  exp_rate: 8'd32};
    vecs[1] = '{mode: 2'b01, secs: 2,  exp_elapsed: 8'd2,  exp_total: 16'd128, exp_rate: 8'd64};
    vecs[2] = '{mode: 2'b11, secs: 11, exp_elapsed: 8'd11, exp_total: 16'd417, exp_rate: 8'd33};
    vecs[3] = '{mode: 2'b10, secs: 1,  exp_elapsed: 8'd1,  exp_total: 16'd128, exp_rate: 8'd128};

    reset = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_pulse", {31'd0, pulse}, 32'd0);
    check("rst_rate", {24'd0, rate}, 32'd0);
    check("rst_total", {16'd0, total_pulses}, 32'd0);
    reset = 1'b1;

    // Reset mid-run takes priority over start, then run-mode pulse timing.
    mode  = 2'b10;
    start = 1'b1;
    @(posedge clk);
    repeat (300) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_running", {31'd0, running}, 32'd0);
    check("midrst_pulse", {31'd0, pulse}, 32'd0);
    check("midrst_tick", {31'd0, sec_tick}, 32'd0);
    check("midrst_rate", {24'd0, rate}, 32'd0);
    check("midrst_elapsed", {24'd0, elapsed_sec}, 32'd0);
    check("midrst_total", {16'd0, total_pulses}, 32'd0);
    reset = 1'b1;
    push_seconds(2'b10, 1);
    @(posedge clk);
    @(negedge clk);
    check("release_running", {31'd0, running}, 32'd1);
    check("run_rate", {24'd0, rate}, 32'd128);
    n = 0;
    found = 0;
    while (n < 20 && found == 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (pulse) found = 1;
    end
    check("first_pulse_edge", n, 8);
    last = n;
    bad = 0;
    for (int k = n + 1; k <= 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pulse) begin
        if ((k - last) != 7 && (k - last) != 8) bad++;
        last = k;
      end
    end
    check("pulse_spacing_bad", bad, 0);
    check("run_total_1s", {16'd0, total_pulses}, 32'd128);
    stop_run();

    // Table-driven constant-rate and hybrid runs.
    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      push_seconds(vecs[v].mode, vecs[v].secs);
      start = 1'b1;
      @(posedge clk);
      repeat (vecs[v].secs * CLK_HZ) @(posedge clk);
      @(negedge clk);
      stop_run();
      check("vec_elapsed", {24'd0, elapsed_sec}, {24'd0, vecs[v].exp_elapsed});
      check("vec_total", {16'd0, total_pulses}, {16'd0, vecs[v].exp_total});
      check("vec_rate", {24'd0, rate}, {24'd0, vecs[v].exp_rate});
      check("vec_queue_drained", exp_q.size(), 0);
    end

    // Mode change mid-second waits for the next tick.
    mode = 2'b00;
    exp_q.push_back({8'd128, 8'd32});
    exp_q.push_back({8'd128, 8'd128});
    start = 1'b1;
    @(posedge clk);
    repeat (500) @(posedge clk);
    @(negedge clk);
    mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    check("switch_rate_held", {24'd0, rate}, 32'd32);
    repeat (1499) @(posedge clk);
    @(negedge clk);
    stop_run();
    check("switch_total", {16'd0, total_pulses}, 32'd160);
    check("switch_elapsed", {24'd0, elapsed_sec}, 32'd2);

    // Stop mid-second: values hold, no trailing pulses, then full restart.
    mode = 2'b00;
    exp_q.push_back({8'd32, 8'd32});
    start = 1'b1;
    @(posedge clk);
    repeat (1500) @(posedge clk);
    @(negedge clk);
    stop_run();
    after = 0;
    repeat (100) begin
      @(negedge clk);
      if (pulse) after++;
    end
    check("idle_no_pulses", after, 0);
    check("idle_elapsed", {24'd0, elapsed_sec}, 32'd1);
    check("idle_total", {16'd0, total_pulses}, 32'd48);
    check("idle_rate", {24'd0, rate}, 32'd32);
    exp_q.push_back({8'd32, 8'd32});
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_running", {31'd0, running}, 32'd1);
    check("restart_elapsed", {24'd0, elapsed_sec}, 32'd0);
    check("restart_total", {16'd0, total_pulses}, 32'd0);
    repeat (CLK_HZ) @(posedge clk);
    @(negedge clk);
    check("restart_total_1s", {16'd0, total_pulses}, 32'd32);
    check("restart_elapsed_1s", {24'd0, elapsed_sec}, 32'd1);
    stop_run();
    check("final_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
